// File: rtl/systolic_pkg.sv
// systolic_pkg: shared systolic-array constants and partial-sum types
package systolic_pkg;
  localparam int COL = 32;
  localparam int DW = 32;
  typedef logic signed [DW-1:0] psum_t;
  typedef psum_t psum_row_t [COL];
endpackage

// File: rtl/psum_row_collector_if.sv
// psum_row_collector_if: column sample inputs and aligned row valid/ready output
interface psum_row_collector_if #(
  parameter int COL = systolic_pkg::COL,
  parameter int DW = systolic_pkg::DW
);
  logic signed [DW-1:0] psum_in [COL];
  logic [COL-1:0] out_en;
  logic signed [DW-1:0] row_data [COL];
  logic row_valid;
  logic row_ready;
  modport master (output psum_in, out_en, row_ready, input row_data, row_valid);
  modport slave (input psum_in, out_en, row_ready, output row_data, row_valid);
endinterface

// File: rtl/psum_col_fifo.sv
// psum_col_fifo: single-column synchronous FIFO; push to a full FIFO is dropped unless popped
module psum_col_fifo #(
  parameter int DW = 32,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic push,
  input  logic pop,
  input  logic signed [DW-1:0] din,
  output logic signed [DW-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic signed [DW-1:0] mem_q [DEPTH];
  logic wr_en;
  assign empty = wr_q == rd_q;
  assign full = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  assign dout = mem_q[rd_q[AW-1:0]];
  // pointer update; clear empties the FIFO by snapping the read pointer to the write pointer
  always_comb begin
    wr_en = push && (!full || pop) && !clear;
    wr_d = wr_q + {{AW{1'b0}}, wr_en};
    rd_d = clear ? wr_q : rd_q + {{AW{1'b0}}, pop && !empty};
  end
  // pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  // storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/psum_row_collector.sv
// psum_row_collector: realigns skewed per-column partial sums into complete rows on valid/ready
module psum_row_collector #(
  parameter int COL = systolic_pkg::COL,
  parameter int DW = systolic_pkg::DW,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  psum_row_collector_if.slave bus,
  output logic [CNT_W-1:0] row_count,
  output logic overflow,
  output logic busy
);
  logic [COL-1:0] empty, full;
  logic signed [DW-1:0] head [COL];
  logic signed [DW-1:0] row_data_q [COL];
  logic signed [DW-1:0] row_data_d [COL];
  logic row_valid_q, row_valid_d, overflow_q, overflow_d;
  logic [CNT_W-1:0] row_count_q, row_count_d;
  logic pop_all, xfer;
  for (genvar j = 0; j < COL; j++) begin : g_col
    psum_col_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .clear(clear),
      .push(bus.out_en[j]),
      .pop(pop_all),
      .din(bus.psum_in[j]),
      .dout(head[j]),
      .full(full[j]),
      .empty(empty[j])
    );
  end
  assign pop_all = ~|empty && (!row_valid_q || bus.row_ready);
  assign xfer = row_valid_q && bus.row_ready;
  // output register, sticky overflow and saturating row counter; clear overrides everything
  always_comb begin
    for (int i = 0; i < COL; i++) row_data_d[i] = clear ? '0 : pop_all ? head[i] : row_data_q[i];
    row_valid_d = !clear && (pop_all || (row_valid_q && !xfer));
    overflow_d = !clear && (overflow_q || |(bus.out_en & full & ~{COL{pop_all}}));
    row_count_d = clear ? '0 : (xfer && !(&row_count_q)) ? row_count_q + {{(CNT_W-1){1'b0}}, 1'b1} : row_count_q;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < COL; i++) row_data_q[i] <= '0;
      row_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      row_count_q <= '0;
    end else begin
      row_data_q <= row_data_d;
      row_valid_q <= row_valid_d;
      overflow_q <= overflow_d;
      row_count_q <= row_count_d;
    end
  end
  assign bus.row_data = row_data_q;
  assign bus.row_valid = row_valid_q;
  assign row_count = row_count_q;
  assign overflow = overflow_q;
  assign busy = !(&empty) || row_valid_q;
endmodule

// File: tb/tb_psum_row_collector.sv
// tb_psum_row_collector: directed checks of row alignment, backpressure, overflow, clear and saturation
module tb_psum_row_collector;
  localparam int COL = 4;
  localparam int DW = 32;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic rst, clear, overflow, busy;
  logic [CNT_W-1:0] row_count;
  int n_assert = 0;
  int n_fail = 0;
  psum_row_collector_if #(.COL(COL), .DW(DW)) bus ();
  psum_row_collector #(.COL(COL), .DW(DW), .FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .bus(bus),
    .row_count(row_count),
    .overflow(overflow),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive_row(input int base, input logic [COL-1:0] en);
    bus.out_en = en;
    for (int j = 0; j < COL; j++) bus.psum_in[j] = base + j;
  endtask
  task automatic push_row(input int base);
    drive_row(base, '1);
    tick();
    bus.out_en = '0;
  endtask
  task automatic check_row(input string tag, input int base);
    chk({tag, "_valid"}, bus.row_valid, 1'b1);
    for (int j = 0; j < COL; j++) chk(tag, bus.row_data[j], base + j);
  endtask
  initial begin
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      clear = 1'($urandom);
      bus.row_ready = 1'($urandom);
      bus.out_en = 4'($urandom);
      for (int j = 0; j < COL; j++) bus.psum_in[j] = $urandom;
      tick();
    end
    chk("rst_valid", bus.row_valid, 1'b0);
    chk("rst_count", row_count, 0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    for (int j = 0; j < COL; j++) chk("rst_data", bus.row_data[j], 0);
    rst = 1'b0;
    clear = 1'b0;
    bus.row_ready = 1'b0;
    drive_row(0, '0);
    tick();
    for (int j = 0; j < COL; j++) begin
      bus.out_en = 4'(1 << j);
      bus.psum_in[j] = 100 + j;
      tick();
      chk("skew_not_yet", bus.row_valid, 1'b0);
    end
    bus.out_en = '0;
    tick();
    check_row("skew_row", 100);
    chk("skew_busy", busy, 1'b1);
    bus.row_ready = 1'b1;
    tick();
    bus.row_ready = 1'b0;
    chk("skew_count", row_count, 1);
    chk("skew_drained", bus.row_valid, 1'b0);
    chk("skew_idle", busy, 1'b0);
    for (int k = 0; k < 5; k++) push_row(200 + 100 * k);
    chk("bp_no_ovf", overflow, 1'b0);
    push_row(700);
    chk("bp_ovf", overflow, 1'b1);
    bus.row_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check_row("bp_drain", 200 + 100 * k);
      tick();
    end
    bus.row_ready = 1'b0;
    chk("bp_empty", bus.row_valid, 1'b0);
    chk("bp_count", row_count, 6);
    chk("bp_ovf_sticky", overflow, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_ovf", overflow, 1'b0);
    chk("clr_count", row_count, 0);
    for (int k = 1; k <= 5; k++) push_row(1000 * k);
    chk("fp_no_ovf0", overflow, 1'b0);
    check_row("fp_head", 1000);
    bus.row_ready = 1'b1;
    push_row(6000);
    chk("fp_no_ovf", overflow, 1'b0);
    for (int k = 2; k <= 6; k++) begin
      check_row("fp_drain", 1000 * k);
      tick();
    end
    bus.row_ready = 1'b0;
    chk("fp_empty", bus.row_valid, 1'b0);
    chk("fp_count", row_count, 6);
    chk("fp_ovf_end", overflow, 1'b0);
    push_row(7000);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive_row(7100 + 100 * i, '1);
      tick();
      check_row("hold", 7000);
    end
    bus.out_en = '0;
    chk("hold_ovf", overflow, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus.row_ready = 1'b1;
    push_row(500);
    tick();
    tick();
    bus.row_ready = 1'b0;
    chk("mc_count_pre", row_count, 1);
    push_row(8000);
    push_row(8100);
    drive_row(8200, 4'b0011);
    tick();
    chk("mc_busy_pre", busy, 1'b1);
    drive_row(9999, '1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus.out_en = '0;
    chk("mc_busy", busy, 1'b0);
    chk("mc_count", row_count, 0);
    chk("mc_ovf", overflow, 1'b0);
    chk("mc_valid", bus.row_valid, 1'b0);
    push_row(8300);
    tick();
    check_row("mc_first", 8300);
    bus.row_ready = 1'b1;
    tick();
    bus.row_ready = 1'b0;
    chk("mc_count_post", row_count, 1);
    push_row(-1000);
    tick();
    check_row("neg_row", -1000);
    bus.row_ready = 1'b1;
    tick();
    chk("neg_count", row_count, 2);
    for (int i = 0; i < 16; i++) push_row(10 * i);
    tick();
    tick();
    chk("sat_count", row_count, 15);
    chk("sat_empty", bus.row_valid, 1'b0);
    chk("sat_ovf", overflow, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
